add_64_iter: RTL and testbench

- Multi-cycle 64-bit signed adder for the Y86-64 ALU path.
- Adds two 64-bit operands one SLICE_W-bit slice per cycle, LSB slice first, with a rippled carry.
- Produces the 64-bit sum, the signed-overflow flag and the carry-out.
- Serves the sequential/pipelined datapath where a full-width single-cycle adder chain is too long. Valid/ready handshake on both input and output.

---
 rtl/add_64_iter.sv | 120 ++++++++++++
 tb/tb_add_64_iter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/add_64_iter.sv
// add_64_iter: multi-cycle 64-bit signed adder, one SLICE_W-bit slice per
// cycle (LSB first) with a rippled carry, valid/ready on both sides.
// Optional subtract mode is enabled by defining ADD_64_ITER_SUB_EN, which
// adds a 'sub' input sampled with the operands.
module add_64_iter #(
   parameter  int SLICE_W = 8,
   localparam int NSLICE  = 64 / SLICE_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
`ifdef ADD_64_ITER_SUB_EN
   input  logic        sub,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] sum,
   output logic        overflow,
   output logic        carry_out
);

   localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_nxt;
   logic [63:0]        a_q, b_q, sum_q, sum_nxt;
   logic               ovf_q, cout_q, carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic               rdy_q;
   logic               sub_q;
   logic [SLICE_W-1:0] a_sl, b_sl, s_nxt;
   logic               c_nxt, last, accept, ovf_nxt;

   // rdy_q keeps in_ready low until the first clock after reset release
   assign in_ready  = rdy_q && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (idx_q == IDX_W'(NSLICE - 1));
   assign sum       = sum_q;
   assign overflow  = ovf_q;
   assign carry_out = cout_q;

   // One slice of the ripple add plus the overflow of the full result
   always_comb begin
      a_sl = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
      b_sl = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
      if (sub_q) b_sl = ~b_sl;
      {c_nxt, s_nxt} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
      sum_nxt = sum_q;
      sum_nxt[int'(idx_q)*SLICE_W +: SLICE_W] = s_nxt;
      // subtraction overflows when operand signs differ (b is negated)
      if (sub_q)
         ovf_nxt = (a_q[63] != b_q[63]) && (sum_nxt[63] != a_q[63]);
      else
         ovf_nxt = (a_q[63] == b_q[63]) && (sum_nxt[63] != a_q[63]);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operand capture, slice accumulation and result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (state_q == IDLE && accept) begin
            a_q    <= a;
            b_q    <= b;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            idx_q  <= '0;
`ifdef ADD_64_ITER_SUB_EN
            // a-b = a + ~b + 1: the +1 enters as the initial carry
            sub_q   <= sub;
            carry_q <= sub;
`else
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
`endif
         end else if (state_q == RUN) begin
            sum_q   <= sum_nxt;
            carry_q <= c_nxt;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
               cout_q <= c_nxt;
               ovf_q  <= ovf_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_add_64_iter.sv
// Directed bench for add_64_iter (default SLICE_W=8, latency 8).
module tb_add_64_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0, b = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] sum;
   logic        overflow, carry_out;

   int total = 0;
   int bad   = 0;

   add_64_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
`ifdef ADD_64_ITER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .overflow(overflow), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   // call at a negedge; returns #1 after the accepting edge
   task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic sv);
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // counts edges after accept until out_valid; -1 on timeout; ends at a negedge
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
         @(posedge clk);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset;
      #2;
      total++; if ({in_ready, out_valid, overflow, carry_out} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, overflow, carry_out}); end
      total++; if (sum !== 64'h0) begin bad++; $display("FAIL reset_sum: got %h expected 0", sum); end
      @(negedge clk); rst_n = 1'b1; #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_pre_edge: got %b expected 0", in_ready); end
      @(posedge clk); @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_post_edge: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic_add;
      int lat;
      out_ready = 1'b1;
      start_op(64'd5, 64'd7, 1'b0);
      wait_done(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL add_latency: got %0d expected 8", lat); end
      total++; if (sum !== 64'd12) begin bad++; $display("FAIL add_sum: got %h expected c", sum); end
      total++; if ({overflow, carry_out} !== 2'b00) begin bad++; $display("FAIL add_flags: got %b expected 00", {overflow, carry_out}); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_ready: got %b expected 0", in_ready); end
      @(posedge clk); @(negedge clk);
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL back_idle: got %b expected 10", {in_ready, out_valid}); end
      total++; if (sum !== 64'd12) begin bad++; $display("FAIL idle_hold: got %h expected c", sum); end
   endtask

   task automatic run_case(input string name, input logic [63:0] av, input logic [63:0] bv,
                           input logic sv, input logic [63:0] es, input logic eo, input logic ec);
      int lat;
      start_op(av, bv, sv);
      wait_done(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL %s_latency: got %0d expected 8", name, lat); end
      chk({name, "_sum"}, sum, es);
      chk({name, "_ovf"}, {63'b0, overflow}, {63'b0, eo});
      chk({name, "_cout"}, {63'b0, carry_out}, {63'b0, ec});
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_carry_overflow;
      run_case("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b0, 1'b1);
      run_case("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
      run_case("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      start_op(64'd20, 64'd22, 1'b0);
      @(negedge clk); @(negedge clk);
      a = 64'd9; b = 64'd9; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(lat);
      total++; if (lat < 0) begin bad++; $display("FAIL bp_timeout: got %0d expected done", lat); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         total++;
         if ({out_valid, in_ready, overflow, carry_out} !== 4'b1000 || sum !== 64'd42) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b r=%b sum=%h expected v=1 r=0 sum=2a", i, out_valid, in_ready, sum);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release: got %b expected 10", {in_ready, out_valid}); end
   endtask

   task automatic test_reset_mid_run;
      start_op(64'd1, 64'd2, 1'b0);
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; #1;
      total++; if (sum !== 64'h0) begin bad++; $display("FAIL midrst_sum: got %h expected 0", sum); end
      total++; if ({in_ready, out_valid, overflow, carry_out} !== 4'b0) begin bad++; $display("FAIL midrst_flags: got %b expected 0000", {in_ready, out_valid, overflow, carry_out}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      run_case("post_rst", 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd99, 1'b0, 1'b1);
   endtask

`ifdef ADD_64_ITER_SUB_EN
   task automatic test_sub;
      run_case("sub_neg", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_case("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
   endtask
`endif

   initial begin
      test_reset;
      test_basic_add;
      test_carry_overflow;
      test_backpressure;
      test_reset_mid_run;
`ifdef ADD_64_ITER_SUB_EN
      test_sub;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
